// File: rtl/stream_pe_converter.sv
// stream_pe_converter: refolds an AXI stream of PE_IN W-bit lanes into PE_OUT lanes, lane 0 first; ports ap_clk/ap_rst_n, in0_T{READY,VALID,DATA}, out0_T{READY,VALID,DATA}
module stream_pe_converter #(
  parameter int W = 4,
  parameter int PE_IN = 4,
  parameter int PE_OUT = 1
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  output logic in0_TREADY,
  input  logic in0_TVALID,
  input  logic [((PE_IN*W+7)/8)*8-1:0] in0_TDATA,
  input  logic out0_TREADY,
  output logic out0_TVALID,
  output logic [((PE_OUT*W+7)/8)*8-1:0] out0_TDATA
);
  localparam int OW = ((PE_OUT*W+7)/8)*8;
  localparam int R = PE_IN > PE_OUT ? PE_IN/PE_OUT : PE_OUT/PE_IN;
  localparam int CW = R > 1 ? $clog2(R) : 1;
  logic in_fire, out_fire, unused_in;
  logic [PE_IN*W-1:0] din;
  assign din = in0_TDATA[PE_IN*W-1:0];
  assign unused_in = ^in0_TDATA;
  assign in_fire = in0_TVALID && in0_TREADY;
  assign out_fire = out0_TVALID && out0_TREADY;
  if (PE_IN % PE_OUT != 0 && PE_OUT % PE_IN != 0) begin : g_bad
    $error("stream_pe_converter: PE_IN and PE_OUT must divide one another");
  end
  if (R == 1) begin : g_pass
    logic [PE_OUT*W-1:0] data_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
        data_q <= '0;
        out0_TVALID <= 1'b0;
      end else if (in_fire) begin
        data_q <= din;
        out0_TVALID <= 1'b1;
      end else if (out_fire) out0_TVALID <= 1'b0;
    assign in0_TREADY = ap_rst_n && (!out0_TVALID || out0_TREADY);
    assign out0_TDATA = OW'(data_q);
  end else if (PE_IN > PE_OUT) begin : g_down
    logic [R-1:0][PE_OUT*W-1:0] buf_q;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(R-1);
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
        buf_q <= '0;
        cnt <= '0;
        out0_TVALID <= 1'b0;
      end else if (in_fire) begin
        buf_q <= din;
        cnt <= '0;
        out0_TVALID <= 1'b1;
      end else if (out_fire) begin
        cnt <= last ? '0 : cnt + CW'(1);
        out0_TVALID <= !last;
      end
    assign in0_TREADY = ap_rst_n && (!out0_TVALID || (out0_TREADY && last));
    assign out0_TDATA = OW'(buf_q[cnt]);
  end else begin : g_up
    // only the first R-1 slices need storage; the completing beat goes straight to the output word
    logic [R-2:0][PE_IN*W-1:0] acc_q;
    logic [PE_OUT*W-1:0] out_q;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(R-1);
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
        acc_q <= '0;
        out_q <= '0;
        cnt <= '0;
        out0_TVALID <= 1'b0;
      end else begin
        if (in_fire) begin
          for (int i = 0; i < R-1; i++) if (cnt == CW'(i)) acc_q[i] <= din;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) out_q <= {din, acc_q};
        end
        if (in_fire && last) out0_TVALID <= 1'b1;
        else if (out_fire) out0_TVALID <= 1'b0;
      end
    // partial beats keep flowing under output stall; only the completing beat waits
    assign in0_TREADY = ap_rst_n && !(out0_TVALID && !out0_TREADY && last);
    assign out0_TDATA = OW'(out_q);
  end
  a_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    out0_TVALID && !out0_TREADY |=> $stable(out0_TDATA));
endmodule
